seq_addsub: RTL and testbench
=============================

Name: seq_addsub

Overview:
Parametrised multi-cycle adder/subtractor; successor to the single-cycle 32-bit add circuit. It processes CHUNK bits per clock, rippling the carry through a registered carry flop. This trades latency for a short critical path. A valid/ready handshake on both sides lets the ALU datapath stall it or stream into it. It reports the result plus signed overflow, unsigned carry-out and zero.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK (elaboration-time check, fatal on violation).
CHUNK, 8, bits added per clock; NCHUNK = WIDTH/CHUNK cycles of compute latency.

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  operation request.
in_ready  output  1  block can accept a request this cycle.
op_sub  input  1  0 = A+B, 1 = A-B (A + ~B + 1).
data_operandA  input  WIDTH  operand A.
data_operandB  input  WIDTH  operand B.
out_valid  output  1  result fields valid.
out_ready  input  1  consumer accepts the result.
data_result  output  WIDTH  sum/difference, modulo 2^WIDTH.
overflow  output  1  signed (two's complement) overflow.
carry_out  output  1  final carry; for subtract, 1 means no borrow (A >= B unsigned).
zero  output  1  data_result == 0.

Behaviour:
- Reset (sync, active-high): state=IDLE; in_ready=1; out_valid=0; data_result=0; overflow=0; carry_out=0; zero=0. Reset overrides all other inputs, including mid-BUSY, where the in-flight op is discarded.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid:
  - register A and B' (B' = op_sub ? ~B : B);
  - carry register = op_sub;
  - chunk index = 0;
  - go to BUSY.
- BUSY: in_ready=0. Each cycle:
  - add chunk[idx] of A and B' plus carry into result chunk[idx];
  - update carry;
  - idx++.
  - After the chunk NCHUNK-1 edge, go to DONE. Operand inputs are ignored while BUSY.
- DONE: out_valid=1; outputs are held stable until out_ready.
  - out_ready=1 and in_valid=0: go to IDLE; out_valid=0 next cycle.
  - out_ready=1 and in_valid=1: in_ready=1 combinationally. The new op is captured and the FSM goes to BUSY (back-to-back, no IDLE bubble).
  - out_ready=0: in_ready=0; hold.
- Latency: accept on edge t, out_valid high after edge t+NCHUNK. Throughput is one op per NCHUNK+1 cycles with out_ready tied high.
- Flags are computed at the final chunk edge:
  - overflow = (A[W-1] == B'[W-1]) && (R[W-1] != A[W-1]);
  - carry_out = final carry;
  - zero = ~|R.
- NCHUNK=1 (CHUNK=WIDTH) is legal: BUSY lasts one cycle.
- data_result during BUSY is don't-care. Only out_valid qualifies it.

Decomposition:
- Shared package/header holds:
  - the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - the NCHUNK derivation;
  - the index width localparam clog2(NCHUNK) with a minimum of 1.
- One sub-module, chunk_adder: combinational CHUNK-bit adder with cin/cout, instantiated once and muxed by idx.

Test Plan:
- Latency and basic add (W=32, C=8, out_ready=1): A=1, B=1 -> out_valid exactly 4 cycles after accept; result 0x00000002; overflow=0, carry=0, zero=0.
- Carry across chunks: 0x000000FF+0x00000001 -> 0x00000100. 0xFFFFFFFF+1 -> 0x00000000 with carry=1, zero=1, overflow=0. Also sweep (1<<i)+(1<<i) for i=0..30 -> 1<<(i+1).
- Signed overflow: 0x7FFFFFFF+1 -> 0x80000000, overflow=1, carry=0. 0x80000000-1 -> 0x7FFFFFFF, overflow=1, carry=1. 0-1 -> 0xFFFFFFFF, overflow=0, carry=0.
- Backpressure:
  - hold out_ready=0 for 5 cycles after out_valid -> result and flags stable, in_ready=0;
  - then raise out_ready with in_valid=1 (5-3) -> new op accepted the same cycle, 0x00000002 after 4 more cycles.
- Reset mid-op: assert reset on the 2nd BUSY cycle -> next cycle all outputs 0, in_ready=1. The next op 7+8 returns 0x0000000F with no residue.
- Parameter sweep: repeat the above with (WIDTH,CHUNK) = (16,4), (32,32), (64,16), checking latency = WIDTH/CHUNK.

Source files
------------

// File: rtl/seq_addsub_pkg.sv
// Shared definitions for the multi-cycle adder/subtractor: FSM encoding and
// chunk-count helpers used to size the datapath.
package seq_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk index needs at least one bit even when a single chunk covers the word.
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk <= 32'sd1) ? 32'sd1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/seq_addsub_chunk_adder.sv
// Combinational CHUNK-bit adder slice with carry in/out; the top reuses one
// instance for every chunk position.
module chunk_adder
    import seq_addsub_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: ripples CHUNK bits per clock through a
// registered carry, with valid/ready handshakes on input and output.
module seq_addsub
    import seq_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             overflow,
    output logic             carry_out,
    output logic             zero
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = calc_idx_w(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if ((WIDTH % CHUNK) != 0) begin : g_param_check
        $fatal(1, "seq_addsub: WIDTH must be a multiple of CHUNK");
    end

    state_t             state_r, state_next_s;
    logic [WIDTH-1:0]   a_r, b_r, res_r, res_next_s;
    logic               carry_r;
    logic [IDX_W-1:0]   idx_r;
    logic               out_valid_r, overflow_r, carry_out_r, zero_r;
    logic               in_ready_s, accept_s, last_s;
    logic [CHUNK-1:0]   a_chunk_s, b_chunk_s, sum_s;
    logic               cout_s;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a    (a_chunk_s),
        .b    (b_chunk_s),
        .cin  (carry_r),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // Select the active chunk and splice its sum into the running result.
    always_comb begin
        a_chunk_s  = a_r[int'(idx_r) * CHUNK +: CHUNK];
        b_chunk_s  = b_r[int'(idx_r) * CHUNK +: CHUNK];
        res_next_s = res_r;
        res_next_s[int'(idx_r) * CHUNK +: CHUNK] = sum_s;
        last_s     = (idx_r == LAST_IDX);
    end

    // Next-state and input-ready decode; DONE hands straight to BUSY when a
    // new request arrives together with out_ready.
    always_comb begin
        state_next_s = state_r;
        in_ready_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) state_next_s = ST_BUSY;
                else          state_next_s = ST_IDLE;
            end
            ST_BUSY: begin
                if (last_s) state_next_s = ST_DONE;
                else        state_next_s = ST_BUSY;
            end
            ST_DONE: begin
                in_ready_s = out_ready;
                if (out_ready) state_next_s = in_valid ? ST_BUSY : ST_IDLE;
                else           state_next_s = ST_DONE;
            end
            default: begin
                state_next_s = ST_IDLE;
                in_ready_s   = 1'b0;
            end
        endcase
    end

    assign accept_s = in_valid && in_ready_s;

    // State register and registered output-valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            out_valid_r <= (state_next_s == ST_DONE);
        end
    end

    // Operand capture, chunk-serial accumulation and final flag evaluation.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_r         <= '0;
            b_r         <= '0;
            res_r       <= '0;
            carry_r     <= 1'b0;
            idx_r       <= '0;
            overflow_r  <= 1'b0;
            carry_out_r <= 1'b0;
            zero_r      <= 1'b0;
        end else if (accept_s) begin
            a_r     <= data_operandA;
            b_r     <= op_sub ? ~data_operandB : data_operandB;
            carry_r <= op_sub;
            idx_r   <= '0;
        end else if (state_r == ST_BUSY) begin
            res_r   <= res_next_s;
            carry_r <= cout_s;
            idx_r   <= idx_r + IDX_W'(1);
            if (last_s) begin
                overflow_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                               (res_next_s[WIDTH-1] != a_r[WIDTH-1]);
                carry_out_r <= cout_s;
                zero_r      <= ~|res_next_s;
            end else begin
                overflow_r  <= overflow_r;
                carry_out_r <= carry_out_r;
                zero_r      <= zero_r;
            end
        end else begin
            res_r <= res_r;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign data_result = res_r;
    assign overflow    = overflow_r;
    assign carry_out   = carry_out_r;
    assign zero        = zero_r;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed-vector bench for seq_addsub across four WIDTH/CHUNK configurations,
// checked every cycle against an arithmetic model with a handshake/latency queue.
module tb_seq_addsub;

    logic        clk = 1'b0;
    logic        reset, in_valid, out_ready, op_sub;
    logic [63:0] a_s, b_s;
    int          sel;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    int cfg_w [4] = '{16, 32, 32, 64};
    int cfg_n [4] = '{4, 4, 1, 4};

    logic        iv_v [4];
    logic        rdy_v [4];
    logic        vld_v [4];
    logic        ov_v [4];
    logic        co_v [4];
    logic        z_v [4];
    logic [15:0] r0;
    logic [31:0] r1, r2;
    logic [63:0] r3;
    logic [63:0] res_m;
    logic        ready_m, valid_m, ov_m, co_m, z_m;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_addsub #(.WIDTH(16), .CHUNK(4)) u0 (
        .clock(clk), .reset(reset), .in_valid(iv_v[0]), .in_ready(rdy_v[0]),
        .op_sub(op_sub), .data_operandA(a_s[15:0]), .data_operandB(b_s[15:0]),
        .out_valid(vld_v[0]), .out_ready(out_ready), .data_result(r0),
        .overflow(ov_v[0]), .carry_out(co_v[0]), .zero(z_v[0]));
    seq_addsub #(.WIDTH(32), .CHUNK(8)) u1 (
        .clock(clk), .reset(reset), .in_valid(iv_v[1]), .in_ready(rdy_v[1]),
        .op_sub(op_sub), .data_operandA(a_s[31:0]), .data_operandB(b_s[31:0]),
        .out_valid(vld_v[1]), .out_ready(out_ready), .data_result(r1),
        .overflow(ov_v[1]), .carry_out(co_v[1]), .zero(z_v[1]));
    seq_addsub #(.WIDTH(32), .CHUNK(32)) u2 (
        .clock(clk), .reset(reset), .in_valid(iv_v[2]), .in_ready(rdy_v[2]),
        .op_sub(op_sub), .data_operandA(a_s[31:0]), .data_operandB(b_s[31:0]),
        .out_valid(vld_v[2]), .out_ready(out_ready), .data_result(r2),
        .overflow(ov_v[2]), .carry_out(co_v[2]), .zero(z_v[2]));
    seq_addsub #(.WIDTH(64), .CHUNK(16)) u3 (
        .clock(clk), .reset(reset), .in_valid(iv_v[3]), .in_ready(rdy_v[3]),
        .op_sub(op_sub), .data_operandA(a_s), .data_operandB(b_s),
        .out_valid(vld_v[3]), .out_ready(out_ready), .data_result(r3),
        .overflow(ov_v[3]), .carry_out(co_v[3]), .zero(z_v[3]));

    always_comb begin
        for (int k = 0; k < 4; k++) iv_v[k] = in_valid && (sel == k);
        ready_m = rdy_v[sel];
        valid_m = vld_v[sel];
        ov_m    = ov_v[sel];
        co_m    = co_v[sel];
        z_m     = z_v[sel];
        case (sel)
            0:       res_m = {48'd0, r0};
            1:       res_m = {32'd0, r1};
            2:       res_m = {32'd0, r2};
            default: res_m = r3;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cfg %0d, cycle %0d): got %h, expected %h", name, sel, cyc, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s timeout (cfg %0d): got no handshake, expected one within bound", name, sel);
    endtask

    // Arithmetic model: unsigned value for result/carry, signed range test for overflow.
    function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic sub, output logic [63:0] r, output logic ov,
                                  output logic co, output logic z);
        logic [63:0]        m;
        logic [71:0]        ua, ub, s;
        logic signed [71:0] sa, sb, ss, lo, hi;
        m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        ua = {8'd0, a & m};
        ub = {8'd0, b & m};
        if (sub) begin
            s  = ua - ub;
            co = (ua >= ub);
        end else begin
            s  = ua + ub;
            co = s[w];
        end
        r  = s[63:0] & m;
        z  = (r == 64'd0);
        sa = $signed(ua);
        sb = $signed(ub);
        if (a[w-1]) sa = sa - (72'sd1 <<< w);
        if (b[w-1]) sb = sb - (72'sd1 <<< w);
        ss = sub ? (sa - sb) : (sa + sb);
        lo = -(72'sd1 <<< (w - 1));
        hi = (72'sd1 <<< (w - 1)) - 72'sd1;
        ov = (ss < lo) || (ss > hi);
    endfunction

    typedef struct {
        logic [63:0] r;
        logic        ov, co, z;
        int          acc;
    } exp_t;

    // Compare process: checks outputs every cycle, then advances the model for the next edge.
    initial begin
        exp_t q[$];
        exp_t e;
        bit   armed = 1'b0;
        bit   after_reset = 1'b0;
        bit   done_exp, ready_exp;
        forever begin
            @(negedge clk);
            done_exp  = (q.size() > 0) && ((cyc - q[0].acc) >= cfg_n[sel]);
            ready_exp = (q.size() == 0) ? 1'b1 : (done_exp ? out_ready : 1'b0);
            if (armed) begin
                chk("in_ready", ready_m, ready_exp);
                chk("out_valid", valid_m, done_exp);
                if (done_exp) begin
                    chk("data_result", res_m, q[0].r);
                    chk("overflow", ov_m, q[0].ov);
                    chk("carry_out", co_m, q[0].co);
                    chk("zero", z_m, q[0].z);
                end else if (q.size() == 0 && after_reset) begin
                    chk("reset_result", res_m, 64'd0);
                    chk("reset_flags", {ov_m, co_m, z_m}, 3'b000);
                end
            end
            if (reset) begin
                q.delete();
                armed       = 1'b1;
                after_reset = 1'b1;
            end else if (armed) begin
                if (done_exp && out_ready) void'(q.pop_front());
                if (in_valid && ready_exp) begin
                    model(cfg_w[sel], a_s, b_s, op_sub, e.r, e.ov, e.co, e.z);
                    e.acc = cyc + 1;
                    q.push_back(e);
                    after_reset = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic sub);
        bit ok = 1'b0;
        a_s = a; b_s = b; op_sub = sub; in_valid = 1'b1;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            if (ready_m) ok = 1'b1;
        end
        tick();
        in_valid = 1'b0;
        if (!ok) timeout("send");
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            if (valid_m) ok = 1'b1;
        end
        tick();
        if (!ok) timeout("out_valid");
    endtask

    task automatic op(input logic [63:0] a, input logic [63:0] b, input logic sub);
        send(a, b, sub);
        wait_valid();
    endtask

    task automatic run_cfg(input int k);
        int          w;
        logic [63:0] m;
        sel = k;
        w   = cfg_w[k];
        m   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
        op(64'd1, 64'd1, 1'b0);
        op(64'h0000_00FF, 64'd1, 1'b0);
        op(m, 64'd1, 1'b0);
        op(m >> 1, 64'd1, 1'b0);
        op(64'd1 << (w - 1), 64'd1, 1'b1);
        op(64'd0, 64'd1, 1'b1);
        op(64'h0123_4567_89AB_CDEF & m, 64'h0FED_CBA9_8765_4321 & m, 1'b1);
        op(64'h8000_0000_0000_4000 & m, 64'hC000_0000_0000_8000 & m, 1'b0);
        for (int i = 0; i < w - 1; i++) op(64'd1 << i, 64'd1 << i, 1'b0);
        // Backpressure: hold the result, then restart back-to-back with 5-3.
        out_ready = 1'b0;
        send(64'd20, 64'd22, 1'b0);
        wait_valid();
        repeat (5) tick();
        out_ready = 1'b1;
        op(64'd5, 64'd3, 1'b1);
        // Reset on the second BUSY cycle discards the in-flight op.
        send(64'h1234, 64'h1111, 1'b0);
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        tick();
        op(64'd7, 64'd8, 1'b0);
        repeat (2) tick();
    endtask

    initial begin
        logic [63:0] r;
        logic        ov, co, z;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op_sub = 1'b0;
        a_s = 64'd0; b_s = 64'd0; sel = 1;
        model(32, 64'd1, 64'd1, 1'b0, r, ov, co, z);
        chk("model_1p1", {r, ov, co, z}, {64'h0000_0002, 3'b000});
        model(32, 64'hFFFF_FFFF, 64'd1, 1'b0, r, ov, co, z);
        chk("model_wrap", {r, ov, co, z}, {64'h0000_0000, 3'b011});
        model(32, 64'h7FFF_FFFF, 64'd1, 1'b0, r, ov, co, z);
        chk("model_posov", {r, ov, co, z}, {64'h8000_0000, 3'b100});
        model(32, 64'h8000_0000, 64'd1, 1'b1, r, ov, co, z);
        chk("model_negov", {r, ov, co, z}, {64'h7FFF_FFFF, 3'b110});
        model(32, 64'd0, 64'd1, 1'b1, r, ov, co, z);
        chk("model_borrow", {r, ov, co, z}, {64'hFFFF_FFFF, 3'b000});
        model(16, 64'h00FF, 64'd1, 1'b0, r, ov, co, z);
        chk("model_w16", {r, ov, co, z}, {64'h0000_0100, 3'b000});
        for (int k = 0; k < 4; k++) run_cfg(k);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
